text_scroll_ctrl: RTL

Controller that sequences a multi-digit 7-segment advertisement display. It holds a message of 5-bit character codes in a small write-port RAM and scrolls the message left, one character per scroll tick. It time-multiplexes the digits, presenting one 5-bit character code and a one-hot digit enable per multiplex slot. The char_code output feeds the existing 5-bit-to-7-segment decoder, and digit_en drives the anode/digit drivers.

---
 rtl/reklama_pkg.sv | 19 +
 rtl/text_scroll_ctrl_tick_gen.sv | 29 ++
 rtl/text_scroll_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/reklama_pkg.sv
// Shared types and constants for the scrolling advertisement display controller.
package reklama_pkg;

  localparam int unsigned CHAR_W = 5;

  // Codes 0-26 are digit/letter glyphs; 27 renders as a blank digit.
  localparam logic [CHAR_W-1:0] CHAR_SPACE = 5'd27;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/text_scroll_ctrl_tick_gen.sv
// Free-running prescaler: pulses tick on the last count of each DIV-cycle period.
module tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/text_scroll_ctrl.sv
// Scrolls a RAM-held message across a multiplexed 7-segment display,
// emitting one character code and a one-hot digit enable per mux slot.
module text_scroll_ctrl
  import reklama_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned MSG_DEPTH  = 32,
  parameter int unsigned SCROLL_DIV = 25000000,
  parameter int unsigned MUX_DIV    = 50000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [4:0]                   wr_data,
  input  logic [$clog2(MSG_DEPTH):0]   msg_len,
  input  logic                         start,
  input  logic                         stop,
  output logic [4:0]                   char_code,
  output logic [NUM_DIGITS-1:0]        digit_en,
  output logic                         running,
  output logic                         wrap
);

  localparam int unsigned AW = $clog2(MSG_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = width_of(NUM_DIGITS);
  localparam int unsigned SW = ((LW > DW) ? LW : DW) + 1;
  localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);

  logic [CHAR_W-1:0]     mem [MSG_DEPTH];
  state_t                state, state_nxt;
  logic [AW-1:0]         offset;
  logic [DW-1:0]         digit_idx;
  logic [LW-1:0]         len_q;
  logic                  start_ok_c, run_hold_c, last_off_c, wrap_c;
  logic                  mux_tick, scroll_tick;
  logic [SW-1:0]         sum_c;
  logic [AW-1:0]         rd_addr_c;
  logic [CHAR_W-1:0]     char_c;
  logic [NUM_DIGITS-1:0] en_c;

  // Message RAM: write-only from outside, read internally for display.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign start_ok_c = start && !stop && (msg_len != '0) && (msg_len <= LW'(MSG_DEPTH));
  assign run_hold_c = (state == RUN) && !stop && !start_ok_c;
  assign last_off_c = (LW'(offset) == (len_q - LW'(1)));
  assign wrap_c     = run_hold_c && scroll_tick && last_off_c;

  tick_gen #(.DIV(MUX_DIV)) u_mux_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok_c),
    .en    (state == RUN),
    .tick  (mux_tick)
  );

  tick_gen #(.DIV(SCROLL_DIV)) u_scroll_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok_c),
    .en    (state == RUN),
    .tick  (scroll_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stop outranks start; a valid start in RUN restarts in place.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok_c) state_nxt = RUN;
      RUN:     if (stop)       state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset    <= '0;
      digit_idx <= '0;
      len_q     <= '0;
    end else if (start_ok_c) begin
      offset    <= '0;
      digit_idx <= '0;
      len_q     <= msg_len;
    end else if (run_hold_c) begin
      if (mux_tick)    digit_idx <= (digit_idx == LAST_DIGIT) ? '0 : digit_idx + DW'(1);
      if (scroll_tick) offset    <= last_off_c ? '0 : offset + AW'(1);
    end
  end

  // Widened sum keeps offset+digit from overflowing before the modulo.
  always_comb begin
    sum_c     = SW'(offset) + SW'(digit_idx);
    rd_addr_c = '0;
    char_c    = CHAR_SPACE;
    en_c      = '0;
    if (len_q != '0) rd_addr_c = AW'(sum_c % SW'(len_q));
    if ((state == RUN) && (state_nxt == RUN)) begin
      char_c = mem[rd_addr_c];
      en_c   = NUM_DIGITS'(1) << digit_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_code <= CHAR_SPACE;
      digit_en  <= '0;
      wrap      <= 1'b0;
    end else begin
      char_code <= char_c;
      digit_en  <= en_c;
      wrap      <= wrap_c;
    end
  end

  assign running = (state == RUN);

endmodule
